// File: rtl/axi_mem_sub.sv
// -----------------------------------------------------------------------------
// axi_mem_sub_pkg / axi_mem_sub
//
// Single-beat AXI subordinate backed by a word-addressed memory array. It is
// the memory endpoint for the fake CPU managers, used directly or behind an
// interconnect.
//
// Write path: AW and W are accepted independently, in either order and with
// any gap. Each is held in its own one-deep slot. Once both slots are full the
// write is committed and a single B beat is returned. Only one write is
// outstanding at a time. Both slots reopen after the B handshake.
//
// Read path: one AR is accepted and held for READ_LATENCY cycles. Memory is
// then sampled and a single R beat (last=1) is returned. AR reopens after the
// R handshake.
//
// Responses: OKAY for len==0 in range, SLVERR for any len!=0, DECERR when the
// word index (addr >> WORD_LSB) is >= MEM_DEPTH. Errored writes leave memory
// untouched. Errored reads return zero data.
//
// Ports:
//   clk                clock, all logic on posedge
//   rst_n              synchronous active-low reset
//   i_axi_s_aw         write address payload   (axi_aw_t)
//   i_axi_s_awvalid    / o_axi_s_awready       AW handshake
//   i_axi_s_w          write data payload      (axi_w_t)
//   i_axi_s_wvalid     / o_axi_s_wready        W handshake
//   o_axi_s_b          write response payload  (axi_b_t)
//   o_axi_s_bvalid     / i_axi_s_bready        B handshake
//   i_axi_s_ar         read address payload    (axi_ar_t)
//   i_axi_s_arvalid    / o_axi_s_arready       AR handshake
//   o_axi_s_r          read data payload       (axi_r_t)
//   o_axi_s_rvalid     / o_axi_s_rready        R handshake (rready is an input)
// -----------------------------------------------------------------------------

package axi_mem_sub_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 64;
   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
   localparam int AXI_ID_WIDTH   = 4;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } axi_resp_e;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
   } axi_aw_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [AXI_STRB_WIDTH-1:0] strb;
   } axi_w_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      axi_resp_e               resp;
   } axi_b_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
   } axi_ar_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      axi_resp_e                 resp;
      logic                      last;
   } axi_r_t;

endpackage

module axi_mem_sub
   import axi_mem_sub_pkg::*;
#(
   parameter int MEM_DEPTH    = 1024,
   parameter int READ_LATENCY = 2,
   parameter int WORD_LSB     = 3
) (
   input  logic    clk,
   input  logic    rst_n,

   input  axi_aw_t i_axi_s_aw,
   output logic    o_axi_s_awready,
   input  logic    i_axi_s_awvalid,

   input  axi_w_t  i_axi_s_w,
   output logic    o_axi_s_wready,
   input  logic    i_axi_s_wvalid,

   output axi_b_t  o_axi_s_b,
   input  logic    i_axi_s_bready,
   output logic    o_axi_s_bvalid,

   input  axi_ar_t i_axi_s_ar,
   output logic    o_axi_s_arready,
   input  logic    i_axi_s_arvalid,

   output axi_r_t  o_axi_s_r,
   input  logic    o_axi_s_rready,
   output logic    o_axi_s_rvalid
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // The counter only ever holds values up to READ_LATENCY-1.
   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

   // Response decode shared by both channels. A burst length error takes
   // precedence over an address decode error.
   function automatic axi_resp_e decode_resp(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                             input logic [7:0]                len);
      logic [AXI_ADDR_WIDTH-1:0] idx;
      idx = addr >> WORD_LSB;
      if (len != 8'd0) begin
         return RESP_SLVERR;
      end else if (idx >= AXI_ADDR_WIDTH'(MEM_DEPTH)) begin
         return RESP_DECERR;
      end
      return RESP_OKAY;
   endfunction

   // Only meaningful when decode_resp() returned OKAY (index in range).
   function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
      return IDX_W'(addr >> WORD_LSB);
   endfunction

   // --------------------------------------------------------------------------
   // Storage
   // --------------------------------------------------------------------------
   logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // --------------------------------------------------------------------------
   // Write channel state
   // --------------------------------------------------------------------------
   axi_aw_t   aw_q;
   axi_w_t    w_q;
   logic      aw_full_q;
   logic      w_full_q;
   logic      b_pending_q;
   logic      bvalid_q;
   axi_b_t    b_q;

   logic      aw_hs;
   logic      w_hs;
   logic      b_hs;
   logic      wr_commit;
   axi_resp_e wr_resp;
   logic [IDX_W-1:0] wr_idx;

   // Readies come straight from the slot flags so a manager sees them in the
   // same cycle. They are forced low while reset is held.
   assign o_axi_s_awready = rst_n & ~aw_full_q;
   assign o_axi_s_wready  = rst_n & ~w_full_q;

   assign aw_hs     = i_axi_s_awvalid & o_axi_s_awready;
   assign w_hs      = i_axi_s_wvalid  & o_axi_s_wready;
   assign b_hs      = bvalid_q & i_axi_s_bready;
   // b_pending keeps a held write from being committed a second time while
   // its B beat is waiting for bready.
   assign wr_commit = aw_full_q & w_full_q & ~b_pending_q;
   assign wr_resp   = decode_resp(aw_q.addr, aw_q.len);
   assign wr_idx    = word_idx(aw_q.addr);

   // NOTE: every clocked block updates state with non-blocking assignments so
   // that all registers sample their inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_q        <= '0;
         w_q         <= '0;
         aw_full_q   <= 1'b0;
         w_full_q    <= 1'b0;
         b_pending_q <= 1'b0;
         bvalid_q    <= 1'b0;
         b_q         <= '0;
      end else begin
         if (aw_hs) begin
            aw_q      <= i_axi_s_aw;
            aw_full_q <= 1'b1;
         end
         if (w_hs) begin
            w_q      <= i_axi_s_w;
            w_full_q <= 1'b1;
         end
         if (wr_commit) begin
            bvalid_q    <= 1'b1;
            b_q.id      <= aw_q.id;
            b_q.resp    <= wr_resp;
            b_pending_q <= 1'b1;
         end
         // A handshake here cannot coincide with wr_commit (bvalid implies
         // b_pending) or with a new AW/W (both slots are full).
         if (b_hs) begin
            bvalid_q    <= 1'b0;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            b_pending_q <= 1'b0;
         end
      end
   end

   // NOTE: the memory array has no reset; clearing it would need a reset
   // port on every word, and its contents survive a reset on purpose.
   always_ff @(posedge clk) begin
      if (rst_n && wr_commit && (wr_resp == RESP_OKAY)) begin
         for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
            if (w_q.strb[i]) begin
               mem_q[wr_idx][8*i +: 8] <= w_q.data[8*i +: 8];
            end
         end
      end
   end

   assign o_axi_s_bvalid = bvalid_q;
   assign o_axi_s_b      = b_q;

   // --------------------------------------------------------------------------
   // Read channel state
   // --------------------------------------------------------------------------
   axi_ar_t    ar_q;
   logic       ar_busy_q;
   logic       rvalid_q;
   logic [CNT_W-1:0] cnt_q;
   axi_r_t     r_q;

   logic       ar_hs;
   logic       r_hs;
   axi_resp_e  rd_resp;
   logic [AXI_DATA_WIDTH-1:0] rd_data;

   assign o_axi_s_arready = rst_n & ~ar_busy_q;

   assign ar_hs   = i_axi_s_arvalid & o_axi_s_arready;
   assign r_hs    = rvalid_q & o_axi_s_rready;
   assign rd_resp = decode_resp(ar_q.addr, ar_q.len);
   // Sampled on the edge rvalid rises. A write committed on that same edge
   // has not landed yet, so the read sees the older contents.
   assign rd_data = (rd_resp == RESP_OKAY) ? mem_q[word_idx(ar_q.addr)] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ar_q      <= '0;
         ar_busy_q <= 1'b0;
         cnt_q     <= '0;
         rvalid_q  <= 1'b0;
         r_q       <= '0;
      end else begin
         if (ar_hs) begin
            ar_q      <= i_axi_s_ar;
            ar_busy_q <= 1'b1;
            cnt_q     <= CNT_LOAD;
         end else if (ar_busy_q && !rvalid_q) begin
            if (cnt_q == '0) begin
               rvalid_q <= 1'b1;
               r_q.id   <= ar_q.id;
               r_q.data <= rd_data;
               r_q.resp <= rd_resp;
               r_q.last <= 1'b1;
            end else begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
         end
         // Exclusive with ar_hs: arready is low while a read is held.
         if (r_hs) begin
            rvalid_q  <= 1'b0;
            ar_busy_q <= 1'b0;
         end
      end
   end

   assign o_axi_s_rvalid = rvalid_q;
   assign o_axi_s_r      = r_q;

endmodule

// File: tb/tb_axi_mem_sub.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_sub
//
// Directed and randomized stimulus against axi_mem_sub. Expected B and R beats
// come from a reference model: a sparse word memory (associative array,
// default 0) plus lists of pending reads and writes, each with the edge at
// which it takes effect. At every edge the model first resolves due reads,
// then applies due writes, so a read and a write landing on the same edge see
// the old data. A monitor on the falling edge compares every presented beat
// against the head of the expectation queues, including its arrival cycle.
// -----------------------------------------------------------------------------

module tb_axi_mem_sub;
   import axi_mem_sub_pkg::*;

   localparam int MEM_DEPTH    = 1024;
   localparam int READ_LATENCY = 2;
   localparam int WORD_LSB     = 3;

   logic    clk = 1'b0;
   logic    rst_n;
   axi_aw_t aw;
   logic    awready, awvalid;
   axi_w_t  w;
   logic    wready, wvalid;
   axi_b_t  b;
   logic    bready, bvalid;
   axi_ar_t ar;
   logic    arready, arvalid;
   axi_r_t  r;
   logic    rready, rvalid;

   always #5 clk = ~clk;

   axi_mem_sub #(
      .MEM_DEPTH   (MEM_DEPTH),
      .READ_LATENCY(READ_LATENCY),
      .WORD_LSB    (WORD_LSB)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_axi_s_aw     (aw),
      .o_axi_s_awready(awready),
      .i_axi_s_awvalid(awvalid),
      .i_axi_s_w      (w),
      .o_axi_s_wready (wready),
      .i_axi_s_wvalid (wvalid),
      .o_axi_s_b      (b),
      .i_axi_s_bready (bready),
      .o_axi_s_bvalid (bvalid),
      .i_axi_s_ar     (ar),
      .o_axi_s_arready(arready),
      .i_axi_s_arvalid(arvalid),
      .o_axi_s_r      (r),
      .o_axi_s_rready (rready),
      .o_axi_s_rvalid (rvalid)
   );

   // Edge counter: after posedge N settles, cyc == N.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
   endtask

   // --------------------------------------------------------------------------
   // Reference model
   // --------------------------------------------------------------------------
   typedef struct { logic [3:0] id; logic [1:0] resp; int due; } exp_b_t;
   typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; int due; } exp_r_t;
   typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; int due; } rd_req_t;
   typedef struct { int word; logic [63:0] data; logic [7:0] strb; int due; } wr_req_t;

   exp_b_t  exp_b_q[$];
   exp_r_t  exp_r_q[$];
   rd_req_t rd_pend_q[$];
   rd_req_t rd_keep_q[$];
   wr_req_t wr_pend_q[$];
   wr_req_t wr_keep_q[$];
   logic [63:0] model_mem [int];

   function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [7:0] len);
      if (len != 8'd0) return 2'd2;
      if ((addr >> WORD_LSB) >= MEM_DEPTH) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [63:0] mem_rd(input int word);
      return model_mem.exists(word) ? model_mem[word] : 64'h0;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rd_keep_q = {};
         foreach (rd_pend_q[i]) begin
            if (rd_pend_q[i].due == cyc) begin
               logic [1:0] rs;
               rs = model_resp(rd_pend_q[i].addr, rd_pend_q[i].len);
               exp_r_q.push_back('{rd_pend_q[i].id,
                                   (rs == 2'd0) ? mem_rd(int'(rd_pend_q[i].addr >> WORD_LSB)) : 64'h0,
                                   rs, rd_pend_q[i].due});
            end else begin
               rd_keep_q.push_back(rd_pend_q[i]);
            end
         end
         rd_pend_q = rd_keep_q;
         wr_keep_q = {};
         foreach (wr_pend_q[i]) begin
            if (wr_pend_q[i].due == cyc) begin
               logic [63:0] mask;
               for (int k = 0; k < 8; k++) mask[8*k +: 8] = {8{wr_pend_q[i].strb[k]}};
               model_mem[wr_pend_q[i].word] = (mem_rd(wr_pend_q[i].word) & ~mask) |
                                              (wr_pend_q[i].data & mask);
            end else begin
               wr_keep_q.push_back(wr_pend_q[i]);
            end
         end
         wr_pend_q = wr_keep_q;
      end
   end

   // --------------------------------------------------------------------------
   // Monitor
   // --------------------------------------------------------------------------
   bit b_prev = 1'b0;
   bit r_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         b_prev = 1'b0;
         r_prev = 1'b0;
      end else begin
         if (bvalid) begin
            if (exp_b_q.size() == 0) begin
               fail("unexpected_b");
            end else begin
               if (!b_prev) check("b_timing", cyc, exp_b_q[0].due);
               check("b_payload", {b.id, b.resp}, {exp_b_q[0].id, exp_b_q[0].resp});
               if (bready) void'(exp_b_q.pop_front());
            end
         end
         b_prev = bvalid && !bready;
         if (rvalid) begin
            if (exp_r_q.size() == 0) begin
               fail("unexpected_r");
            end else begin
               if (!r_prev) check("r_timing", cyc, exp_r_q[0].due);
               check("r_payload", {r.id, r.data, r.resp, r.last},
                     {exp_r_q[0].id, exp_r_q[0].data, exp_r_q[0].resp, 1'b1});
               if (rready) void'(exp_r_q.pop_front());
            end
         end
         r_prev = rvalid && !rready;
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus tasks (entered #1 after a rising edge)
   // --------------------------------------------------------------------------
   task automatic send_aw(input logic [31:0] a_addr, input logic [3:0] a_id,
                          input logic [7:0] a_len, input int dly, output int hs);
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1;
      end
      aw = '{id: a_id, addr: a_addr, len: a_len};
      awvalid = 1'b1;
      hs = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (awready) begin
            @(posedge clk);
            #1;
            hs = cyc;
            break;
         end
      end
      awvalid = 1'b0;
      if (hs < 0) fail("aw_accept");
   endtask

   task automatic send_w(input logic [63:0] a_data, input logic [7:0] a_strb,
                         input int dly, output int hs);
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1;
      end
      w = '{data: a_data, strb: a_strb};
      wvalid = 1'b1;
      hs = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (wready) begin
            @(posedge clk);
            #1;
            hs = cyc;
            break;
         end
      end
      wvalid = 1'b0;
      if (hs < 0) fail("w_accept");
   endtask

   task automatic do_write(input logic [31:0] a_addr, input logic [3:0] a_id, input logic [7:0] a_len,
                           input logic [63:0] a_data, input logic [7:0] a_strb,
                           input int aw_dly, input int w_dly, input int hold);
      int ca, cw, due;
      logic [1:0] rs;
      bit seen;
      fork
         send_aw(a_addr, a_id, a_len, aw_dly, ca);
         send_w(a_data, a_strb, w_dly, cw);
      join
      if (ca < 0 || cw < 0) return;
      due = ((ca > cw) ? ca : cw) + 1;
      rs  = model_resp(a_addr, a_len);
      exp_b_q.push_back('{a_id, rs, due});
      if (rs == 2'd0) wr_pend_q.push_back('{int'(a_addr >> WORD_LSB), a_data, a_strb, due});
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bvalid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         fail("b_arrival");
         return;
      end
      repeat (hold) begin
         @(negedge clk);
         check("aw_w_blocked", {awready, wready}, 2'b00);
      end
      @(posedge clk);
      #1 bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
      @(negedge clk);
      check("aw_w_reopen", {awready, wready}, 2'b11);
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a_addr, input logic [3:0] a_id, input logic [7:0] a_len,
                          input int dly, input int hold);
      int hs;
      bit seen;
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1;
      end
      ar = '{id: a_id, addr: a_addr, len: a_len};
      arvalid = 1'b1;
      hs = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (arready) begin
            @(posedge clk);
            #1;
            hs = cyc;
            break;
         end
      end
      arvalid = 1'b0;
      if (hs < 0) begin
         fail("ar_accept");
         return;
      end
      rd_pend_q.push_back('{a_addr, a_len, a_id, hs + READ_LATENCY});
      seen = 1'b0;
      for (int k = 0; k < READ_LATENCY + 20; k++) begin
         @(negedge clk);
         if (rvalid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         fail("r_arrival");
         return;
      end
      repeat (hold) begin
         @(negedge clk);
         check("ar_blocked", arready, 1'b0);
      end
      @(posedge clk);
      #1 rready = 1'b1;
      @(posedge clk);
      #1 rready = 1'b0;
      @(negedge clk);
      check("ar_reopen", arready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   // Small address pool so reads and writes collide; occasional out-of-range.
   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return (MEM_DEPTH + $urandom_range(0, 15)) << WORD_LSB;
      return ($urandom_range(0, 15) << WORD_LSB) | $urandom_range(0, 7);
   endfunction

   function automatic logic [7:0] rand_len(input logic [31:0] addr);
      if ((addr >> WORD_LSB) < MEM_DEPTH && $urandom_range(0, 7) == 0) return 8'd1;
      return 8'd0;
   endfunction

   // --------------------------------------------------------------------------
   // Main sequence
   // --------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      aw = '0; awvalid = 1'b0;
      w  = '0; wvalid  = 1'b0;
      ar = '0; arvalid = 1'b0;
      bready = 1'b0;
      rready = 1'b0;

      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("reset_valids", {bvalid, rvalid}, 2'b00);
         check("reset_readies", {awready, wready, arready}, 3'b000);
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_reset", {awready, wready, arready}, 3'b111);
      @(posedge clk);
      #1;

      // AW first, W three cycles later, then read back.
      do_write(32'h18, 4'd2, 8'd0, 64'hdeadbeefcafef00d, 8'hFF, 0, 3, 0);
      do_read(32'h18, 4'd5, 8'd0, 0, 0);
      // W first, partial strobe.
      do_write(32'h18, 4'd1, 8'd0, 64'h1111111122222222, 8'h0F, 2, 0, 0);
      do_read(32'h18, 4'd3, 8'd0, 0, 0);
      // Same-cycle AW/W, then backpressure on both response channels.
      do_write(32'h20, 4'd3, 8'd0, 64'h0123456789abcdef, 8'hFF, 0, 0, 5);
      do_read(32'h20, 4'd4, 8'd0, 0, 5);
      // Length error leaves memory alone; out-of-range read decodes.
      do_write(32'h18, 4'd6, 8'd1, 64'hffffffffffffffff, 8'hFF, 0, 0, 0);
      do_read(32'h18, 4'd7, 8'd0, 0, 0);
      do_read(MEM_DEPTH << WORD_LSB, 4'd8, 8'd0, 0, 0);
      do_write(MEM_DEPTH << WORD_LSB, 4'd9, 8'd0, 64'h5555, 8'hFF, 1, 0, 0);

      // Reset while the latency counter is at 1: the read is dropped.
      ar = '{id: 4'd10, addr: 32'h20, len: 8'd0};
      arvalid = 1'b1;
      @(negedge clk);
      check("ar_ready_pre_rst", arready, 1'b1);
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      rst_n = 1'b0;
      rd_pend_q.delete();
      exp_r_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < READ_LATENCY + 4; k++) begin
         @(negedge clk);
         check("rst_drop_read", {rvalid, arready}, 2'b01);
      end
      @(posedge clk);
      #1;

      // Randomized concurrent traffic.
      fork
         for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = rand_addr();
            do_write(a, 4'($urandom), rand_len(a), {$urandom, $urandom}, 8'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         end
         for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = rand_addr();
            do_read(a, 4'($urandom), rand_len(a), $urandom_range(0, 3), $urandom_range(0, 3));
         end
      join

      repeat (5) @(posedge clk);
      check("b_queue_drained", exp_b_q.size(), 0);
      check("r_queue_drained", exp_r_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
